// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg
//   Shared types and constants for the datapath micro-sequencer.
//   - state_t   : sequencer states (IDLE, ISSUE, WRITE, DONE)
//   - RA_W/FS_W : register-address and function-select widths
//   - ZERO_REG  : hard-wired zero register; writes to it are discarded
//   - FS_*      : ALU function-select encodings used by the controller
package datapath_ctrl_pkg;

    localparam int unsigned RA_W = 5;
    localparam int unsigned FS_W = 5;

    localparam logic [4:0] ZERO_REG  = 5'd31;

    // ALU function select: route operand B straight through.
    localparam logic [4:0] FS_PASS_B = 5'b01000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Any state other than IDLE means a sequence owns the datapath.
    function automatic logic st_active(input state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/datapath_ctrl_iter.sv
// datapath_ctrl_iter
//   Destination / immediate / remaining-iteration counter for one sequence.
//   Ports:
//     clock, reset         rising-edge clock, async active-low reset
//     load                 capture *_init values (start of a sequence)
//     step                 advance to next iteration: da+1, k+1 if inc_k,
//                          remaining-1
//     da_init, k_init      first destination address, first immediate
//     count_init           iterations minus one
//     inc_k_init           increment k on every step
//     da, k                current destination address and immediate
//     last                 current iteration is the final one
module datapath_ctrl_iter #(
    parameter int unsigned DW   = 64,
    parameter int unsigned RA_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [RA_W-1:0] da_init,
    input  logic [DW-1:0]   k_init,
    input  logic [RA_W-1:0] count_init,
    input  logic            inc_k_init,
    output logic [RA_W-1:0] da,
    output logic [DW-1:0]   k,
    output logic            last
);

    logic [RA_W-1:0] da_q;
    logic [DW-1:0]   k_q;
    logic [RA_W-1:0] rem_q;
    logic            inc_k_q;

    // da and k wrap naturally at their register widths (31 -> 0, 2^DW-1 -> 0).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            da_q    <= '0;
            k_q     <= '0;
            rem_q   <= '0;
            inc_k_q <= 1'b0;
        end else if (load) begin
            da_q    <= da_init;
            k_q     <= k_init;
            rem_q   <= count_init;
            inc_k_q <= inc_k_init;
        end else if (step) begin
            da_q  <= da_q + RA_W'(1);
            rem_q <= rem_q - RA_W'(1);
            if (inc_k_q) begin
                k_q <= k_q + DW'(1);
            end
        end
    end

    assign da   = da_q;
    assign k    = k_q;
    assign last = (rem_q == '0);

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl
//   Micro-sequencer driving the control word of the 32 x 64-bit
//   register-file/ALU datapath. One instruction is accepted per
//   instr_valid/instr_ready handshake and repeated over instr_count+1
//   consecutive destination registers, two cycles (ISSUE, WRITE) each.
//   Ports:
//     clock, reset            rising-edge clock, async active-low reset
//     instr_valid/instr_ready instruction handshake
//     instr_fs/aa/ba/da       function select, source A/B, first destination
//     instr_imm               immediate presented on K
//     instr_use_imm           B operand is K (Bselect)
//     instr_bypass            bus driven by B (EN_B) instead of ALU (EN_ALU)
//     instr_cin               ALU carry-in
//     instr_count             iterations minus one
//     instr_inc_k             K += 1 after each iteration
//     busy, done              sequence in progress / one-cycle completion pulse
//     FS, AA, BA, DA, K       datapath operand/function fields
//     write, Bselect, EN_B, EN_ALU, cin  datapath strobes
//   Build option:
//     DATAPATH_CTRL_RF_CLEAR_EN  after reset, sweep-clear registers 0..30
//                                before accepting the first instruction.
module datapath_ctrl #(
    parameter int unsigned DW   = 64,
    parameter int unsigned RA_W = 5,
    parameter int unsigned FS_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [FS_W-1:0] instr_fs,
    input  logic [RA_W-1:0] instr_aa,
    input  logic [RA_W-1:0] instr_ba,
    input  logic [RA_W-1:0] instr_da,
    input  logic [DW-1:0]   instr_imm,
    input  logic            instr_use_imm,
    input  logic            instr_bypass,
    input  logic            instr_cin,
    input  logic [RA_W-1:0] instr_count,
    input  logic            instr_inc_k,
    output logic            busy,
    output logic            done,
    output logic [FS_W-1:0] FS,
    output logic [RA_W-1:0] AA,
    output logic [RA_W-1:0] BA,
    output logic [RA_W-1:0] DA,
    output logic [DW-1:0]   K,
    output logic            write,
    output logic            Bselect,
    output logic            EN_B,
    output logic            EN_ALU,
    output logic            cin
);

    import datapath_ctrl_pkg::*;

    state_t state_q, state_d;

    logic [FS_W-1:0] fs_q;
    logic [RA_W-1:0] aa_q, ba_q;
    logic            use_imm_q, bypass_q, cin_q;

    logic            accept, load, step, last, drive_word;
    logic            clr_pend, start_sweep;

    logic [FS_W-1:0] ld_fs;
    logic [RA_W-1:0] ld_aa, ld_ba, ld_da, ld_count;
    logic [DW-1:0]   ld_imm;
    logic            ld_use_imm, ld_bypass, ld_cin, ld_inc_k;

`ifdef DATAPATH_CTRL_RF_CLEAR_EN
    // Set by reset; the clear sweep is an ordinary ISSUE/WRITE sequence
    // whose final write returns to IDLE without a done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clr_pend <= 1'b1;
        end else if (state_q == ST_WRITE && last) begin
            clr_pend <= 1'b0;
        end
    end
`else
    assign clr_pend = 1'b0;
`endif

    assign instr_ready = (state_q == ST_IDLE) && !clr_pend;
    assign accept      = instr_valid && instr_ready;
    assign start_sweep = (state_q == ST_IDLE) && clr_pend;
    assign load        = accept || start_sweep;
    assign step        = (state_q == ST_WRITE) && !last;

    // Source of the fields captured on load: the instruction port, or the
    // fixed pass-B-of-zero word that clears registers 0..30.
    always_comb begin
        ld_fs      = instr_fs;
        ld_aa      = instr_aa;
        ld_ba      = instr_ba;
        ld_da      = instr_da;
        ld_imm     = instr_imm;
        ld_use_imm = instr_use_imm;
        ld_bypass  = instr_bypass;
        ld_cin     = instr_cin;
        ld_count   = instr_count;
        ld_inc_k   = instr_inc_k;
        if (start_sweep) begin
            ld_fs      = FS_PASS_B;
            ld_aa      = ZERO_REG;
            ld_ba      = ZERO_REG;
            ld_da      = '0;
            ld_imm     = '0;
            ld_use_imm = 1'b1;
            ld_bypass  = 1'b0;
            ld_cin     = 1'b0;
            ld_count   = ZERO_REG - 5'd1;
            ld_inc_k   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fs_q      <= '0;
            aa_q      <= '0;
            ba_q      <= '0;
            use_imm_q <= 1'b0;
            bypass_q  <= 1'b0;
            cin_q     <= 1'b0;
        end else if (load) begin
            fs_q      <= ld_fs;
            aa_q      <= ld_aa;
            ba_q      <= ld_ba;
            use_imm_q <= ld_use_imm;
            bypass_q  <= ld_bypass;
            cin_q     <= ld_cin;
        end
    end

    datapath_ctrl_iter #(
        .DW   (DW),
        .RA_W (RA_W)
    ) u_iter (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .da_init    (ld_da),
        .k_init     (ld_imm),
        .count_init (ld_count),
        .inc_k_init (ld_inc_k),
        .da         (DA),
        .k          (K),
        .last       (last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WRITE;
            ST_WRITE: begin
                if (!last)        state_d = ST_ISSUE;
                else if (clr_pend) state_d = ST_IDLE;
                else              state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so that an async
    // reset drops write and both bus enables immediately.
    assign drive_word = (state_q == ST_ISSUE) || (state_q == ST_WRITE);
    assign write      = (state_q == ST_WRITE);
    assign EN_ALU     = drive_word && !bypass_q;
    assign EN_B       = drive_word &&  bypass_q;
    assign busy       = st_active(state_q);
    assign done       = (state_q == ST_DONE);

    assign FS      = fs_q;
    assign AA      = aa_q;
    assign BA      = ba_q;
    assign Bselect = use_imm_q;
    assign cin     = cin_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl
//   Randomised and directed bench for datapath_ctrl. Expected control words
//   are computed per iteration from the instruction fields: destination
//   (da + i) mod 32, immediate imm + i (when inc_k), done 2*(count+1)+1
//   cycles after accept. A small register-file capture checks the values
//   that pass-B-of-K sequences leave behind.
module tb_datapath_ctrl;

    import datapath_ctrl_pkg::*;

    typedef struct {
        logic [4:0]  fs, aa, ba, da, count;
        logic [63:0] imm;
        logic        use_imm, bypass, cin, inc_k;
    } ins_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid, instr_ready;
    logic [4:0]  instr_fs, instr_aa, instr_ba, instr_da, instr_count;
    logic [63:0] instr_imm;
    logic        instr_use_imm, instr_bypass, instr_cin, instr_inc_k;
    logic        busy, done;
    logic [4:0]  FS, AA, BA, DA;
    logic [63:0] K;
    logic        write, Bselect, EN_B, EN_ALU, cin;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned n_done  = 0;
    logic [63:0] rf [32];

    datapath_ctrl #(
        .DW   (64),
        .RA_W (5),
        .FS_W (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_fs      (instr_fs),
        .instr_aa      (instr_aa),
        .instr_ba      (instr_ba),
        .instr_da      (instr_da),
        .instr_imm     (instr_imm),
        .instr_use_imm (instr_use_imm),
        .instr_bypass  (instr_bypass),
        .instr_cin     (instr_cin),
        .instr_count   (instr_count),
        .instr_inc_k   (instr_inc_k),
        .busy          (busy),
        .done          (done),
        .FS            (FS),
        .AA            (AA),
        .BA            (BA),
        .DA            (DA),
        .K             (K),
        .write         (write),
        .Bselect       (Bselect),
        .EN_B          (EN_B),
        .EN_ALU        (EN_ALU),
        .cin           (cin)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Bus contention must never occur, whatever the sequence is doing.
    always @(negedge clock) chk("bus_excl", 64'(EN_ALU & EN_B), 64'd0);

    always @(negedge clock) if (done) n_done++;

    // Register file behaviour for pass-B-of-K writes; r31 discards writes.
    always @(negedge clock) begin
        if (reset && write && EN_ALU && Bselect && FS == FS_PASS_B && DA != 5'd31)
            rf[DA] = K;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input ins_t in);
        instr_fs      = in.fs;
        instr_aa      = in.aa;
        instr_ba      = in.ba;
        instr_da      = in.da;
        instr_imm     = in.imm;
        instr_use_imm = in.use_imm;
        instr_bypass  = in.bypass;
        instr_cin     = in.cin;
        instr_count   = in.count;
        instr_inc_k   = in.inc_k;
    endtask

    function automatic ins_t rand_ins(input int unsigned max_count);
        ins_t r;
        r.fs      = 5'($urandom);
        r.aa      = 5'($urandom);
        r.ba      = 5'($urandom);
        r.da      = 5'($urandom);
        r.count   = 5'($urandom_range(0, max_count));
        r.imm     = {$urandom, $urandom};
        r.use_imm = 1'($urandom);
        r.bypass  = 1'($urandom);
        r.cin     = 1'($urandom);
        r.inc_k   = 1'($urandom);
        return r;
    endfunction

    function automatic ins_t mk(input logic [4:0] fs, input logic [4:0] da, input logic [63:0] imm,
                                input logic [4:0] count, input logic inc_k, input logic bypass);
        ins_t r;
        r.fs = fs; r.aa = 5'd7; r.ba = 5'd9; r.da = da; r.count = count;
        r.imm = imm; r.use_imm = 1'b1; r.bypass = bypass; r.cin = 1'b0; r.inc_k = inc_k;
        return r;
    endfunction

    task automatic check_word(input string ph, input ins_t in, input logic [4:0] eda,
                              input logic [63:0] ek, input logic wr);
        chk({ph, "_fs"},    64'(FS),      64'(in.fs));
        chk({ph, "_aa"},    64'(AA),      64'(in.aa));
        chk({ph, "_ba"},    64'(BA),      64'(in.ba));
        chk({ph, "_da"},    64'(DA),      64'(eda));
        chk({ph, "_k"},     K,            ek);
        chk({ph, "_bsel"},  64'(Bselect), 64'(in.use_imm));
        chk({ph, "_cin"},   64'(cin),     64'(in.cin));
        chk({ph, "_enalu"}, 64'(EN_ALU),  64'(!in.bypass));
        chk({ph, "_enb"},   64'(EN_B),    64'(in.bypass));
        chk({ph, "_write"}, 64'(write),   64'(wr));
        chk({ph, "_busy"},  64'(busy),    64'd1);
        chk({ph, "_ready"}, 64'(instr_ready), 64'd0);
        chk({ph, "_done"},  64'(done),    64'd0);
    endtask

    // Accept one instruction and follow it cycle by cycle. abort_iter >= 0
    // pulls reset low during the WRITE cycle of that iteration.
    task automatic run(input ins_t in, input int abort_iter);
        int unsigned guard = 0;
        int unsigned dn;
        logic [4:0]  eda;
        logic [63:0] ek;
        @(negedge clock);
        while (!instr_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        chk("accept_ready", 64'(instr_ready), 64'd1);
        drive(in);
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        drive(rand_ins(31));
        eda = in.da;
        ek  = in.imm;
        for (int i = 0; i <= int'(in.count); i++) begin
            eda = 5'((int'(in.da) + i) % 32);
            ek  = in.imm + (in.inc_k ? 64'(i) : 64'd0);
            @(negedge clock);
            check_word("issue", in, eda, ek, 1'b0);
            @(negedge clock);
            check_word("write", in, eda, ek, 1'b1);
            if (i == abort_iter) begin
                #1 reset = 1'b0;
                #1;
                chk("abort_write", 64'(write), 64'd0);
                chk("abort_busy",  64'(busy),  64'd0);
                chk("abort_done",  64'(done),  64'd0);
                chk("abort_en",    64'({EN_ALU, EN_B}), 64'd0);
                chk("abort_k",     K, 64'd0);
                dn = n_done;
                @(negedge clock);
                reset = 1'b1;
                repeat (4) @(negedge clock);
                chk("abort_no_done", 64'(n_done), 64'(dn));
                return;
            end
        end
        @(negedge clock);
        chk("done_pulse", 64'(done),   64'd1);
        chk("done_write", 64'(write),  64'd0);
        chk("done_en",    64'({EN_ALU, EN_B}), 64'd0);
        chk("done_busy",  64'(busy),   64'd1);
        chk("done_ready", 64'(instr_ready), 64'd0);
        chk("done_da",    64'(DA),     64'(eda));
        chk("done_k",     K,           ek);
        @(negedge clock);
        chk("idle_done",  64'(done),   64'd0);
        chk("idle_busy",  64'(busy),   64'd0);
        chk("idle_ready", 64'(instr_ready), 64'd1);
        chk("idle_write", 64'(write),  64'd0);
        chk("idle_da",    64'(DA),     64'(eda));
    endtask

    initial begin
        int unsigned guard;
        for (int r = 0; r < 32; r++) rf[r] = '0;
        instr_valid = 1'b0;
        drive(mk(5'd0, 5'd0, 64'd0, 5'd0, 1'b0, 1'b0));
        repeat (2) @(negedge clock);
        chk("rst_ctrl", 64'({FS, AA, BA, DA}), 64'd0);
        chk("rst_k",    K, 64'd0);
        chk("rst_strb", 64'({write, Bselect, EN_B, EN_ALU, cin}), 64'd0);
        chk("rst_stat", 64'({busy, done}), 64'd0);
        reset = 1'b1;
`ifdef DATAPATH_CTRL_RF_CLEAR_EN
        guard = 0;
        @(negedge clock);
        while (!busy && guard < 4) begin
            @(negedge clock);
            guard++;
        end
        for (int j = 0; j < 62; j++) begin
            chk("sweep_busy",  64'(busy),  64'd1);
            chk("sweep_ready", 64'(instr_ready), 64'd0);
            chk("sweep_da",    64'(DA),    64'(j / 2));
            chk("sweep_write", 64'(write), 64'(j % 2));
            chk("sweep_enalu", 64'(EN_ALU), 64'd1);
            chk("sweep_fs",    64'(FS),    64'(5'b01000));
            chk("sweep_aa",    64'(AA),    64'd31);
            chk("sweep_bsel",  64'(Bselect), 64'd1);
            chk("sweep_k",     K,          64'd0);
            @(negedge clock);
        end
        chk("sweep_end_busy",  64'(busy), 64'd0);
        chk("sweep_end_ready", 64'(instr_ready), 64'd1);
        chk("sweep_no_done",   64'(n_done), 64'd0);
`else
        guard = 0;
        @(negedge clock);
        chk("post_rst_ready", 64'(instr_ready), 64'd1);
        chk("post_rst_busy",  64'(busy), 64'd0);
`endif

        // Single pass-B op into r3.
        run(mk(5'b01000, 5'd3, 64'h5, 5'd0, 1'b0, 1'b0), -1);
        chk("r3", rf[3], 64'h5);

        // Block fill r0..r9 with 0..9.
        run(mk(5'b01000, 5'd0, 64'd0, 5'd9, 1'b1, 1'b0), -1);
        for (int r = 0; r < 10; r++) chk("fill_rf", rf[r], 64'(r));

        // Destination wrap 30, 31, 0, 1.
        run(mk(5'b01000, 5'd30, 64'h77, 5'd3, 1'b0, 1'b0), -1);
        chk("wrap_r30", rf[30], 64'h77);
        chk("wrap_r0",  rf[0],  64'h77);
        chk("wrap_r1",  rf[1],  64'h77);

        // K wraps modulo 2^64.
        run(mk(5'b00010, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 5'd3, 1'b1, 1'b0), -1);

        // Bus driven by B for the whole sequence.
        run(mk(5'b00101, 5'd20, 64'h1234, 5'd4, 1'b1, 1'b1), -1);

        // Longest sequence.
        run(mk(5'b01000, 5'd5, 64'h100, 5'd31, 1'b1, 1'b0), -1);

        for (int n = 0; n < 12; n++) run(rand_ins(6), -1);

        // Reset during the WRITE cycle of the second iteration, then recover.
        run(mk(5'b01000, 5'd10, 64'h20, 5'd5, 1'b1, 1'b0), 1);
        run(mk(5'b01000, 5'd12, 64'h40, 5'd1, 1'b0, 1'b0), -1);
        chk("recover_r13", rf[13], 64'h40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Micro-sequencer that drives the control word of the 32 x 64-bit register-file/ALU datapath: FS, AA, BA, DA, K, write, Bselect, EN_B, EN_ALU, cin.
- Accepts one instruction per valid/ready handshake.
- An instruction can repeat its operation over consecutive destination registers, optionally incrementing K each pass (block fill/copy).
- Sits between the instruction source (test sequencer or a future decoder) and the datapath.

Parameters:
- DW, 64, data/immediate width; matches datapath K.
- RA_W, 5, register address width (32 registers).
- FS_W, 5, function-select width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller can accept
- instr_fs  in  FS_W  ALU function select
- instr_aa  in  RA_W  source A address
- instr_ba  in  RA_W  source B address
- instr_da  in  RA_W  first destination address
- instr_imm  in  DW  immediate for K
- instr_use_imm  in  1  1: B operand = K (Bselect=1); 0: register B
- instr_bypass  in  1  1: bus driven by B (EN_B); 0: by ALU (EN_ALU)
- instr_cin  in  1  ALU carry-in
- instr_count  in  RA_W  iterations minus one (0 to 31)
- instr_inc_k  in  1  K += 1 after each iteration
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse after final write
- FS  out  FS_W  to datapath
- AA, BA, DA  out  RA_W each  to datapath
- K  out  DW  to datapath
- write, Bselect, EN_B, EN_ALU, cin  out  1 each  to datapath

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all control outputs 0; K=0.
  - busy=0, done=0; instr_ready=1 once reset deasserts (subject to the optional feature).
- States: IDLE, ISSUE, WRITE, DONE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at edge: latch all instr_* fields; load remaining=instr_count; go to ISSUE.
- ISSUE:
  - Drive FS/AA/BA/DA/K/Bselect/cin.
  - EN_ALU=~bypass, EN_B=bypass; write=0 (operands settle one cycle).
  - Next: WRITE.
- WRITE:
  - Same control word with write=1; the datapath captures at the edge ending this cycle.
  - At that edge: if remaining==0 go to DONE; else DA<=DA+1 (mod 32, 31 wraps to 0), K<=K+1 if inc_k (mod 2^DW), remaining-=1, go to ISSUE.
- DONE: done=1 for one cycle; all enables and write=0; then IDLE.
- Timing:
  - 2 cycles per iteration; accept-to-done = 2*(count+1)+1 cycles.
  - No back-to-back accept: instr_ready=0 in ISSUE/WRITE/DONE.
- busy=1 in ISSUE, WRITE and DONE.
- Outside ISSUE/WRITE: EN_ALU=EN_B=write=0; FS/AA/BA/DA/K hold their last values.
- Invariant: EN_ALU and EN_B are never both 1 (bus contention).
- Writes to DA=31 are issued unchanged; register 31 is the zero register, so the datapath discards them.
- reset asserted mid-sequence: immediate return to IDLE, write drops asynchronously, no done pulse.
- instr_* changes while busy are ignored; the latched copy is used.

Optional Feature:
- Macro DATAPATH_CTRL_RF_CLEAR_EN.
- Defined:
  - After reset deasserts, the controller runs an automatic clear sweep before accepting any instruction: FS=5'b01000 (pass B), AA=31, Bselect=1, K=0, EN_ALU=1, DA from 0 to 30, 2 cycles each.
  - instr_ready=0 and busy=1 during the sweep; no done pulse at its end.
- Undefined: no sweep; IDLE immediately after reset.

Decomposition:
- Package datapath_ctrl_pkg:
  - State enum.
  - FS constants (FS_PASS_B=5'b01000, others as the ALU defines them).
  - RA_W, FS_W, ZERO_REG=5'd31.
- One sub-module, datapath_ctrl_iter: DA/K/remaining counter with load, step and last flag.

Test Plan:
1. Reset low, then high -> all outputs 0, instr_ready=1 next cycle; with RF_CLEAR_EN: 62 busy cycles, DA sweeps 0 to 30 with write on odd cycles, then instr_ready=1.
2. Single op: fs=01000, use_imm=1, imm=0x5, da=3, count=0 -> ISSUE then WRITE with DA=3, K=5, write=1; done 3 cycles after accept; r3=5.
3. Block fill: da=0, imm=0, inc_k=1, count=9 -> ten writes, r0..r9 = 0..9, done at accept+21.
4. Wrap: da=30, count=3 -> DA sequence 30, 31, 0, 1; r31 stays 0.
5. Bypass op: instr_bypass=1 -> EN_B=1 and EN_ALU=0 for the whole sequence; assertion that EN_ALU&EN_B is never 1.
6. Reset pulled low during the WRITE cycle of iteration 2 -> write=0 immediately, state IDLE, no done pulse; the next instruction executes normally.
